// File: rtl/gc_pkg.sv
// Shared types, defaults and the range test used by the loop dispatcher.
package gc_pkg;

    localparam int N_CORE_DEF   = 4;
    localparam int GC_WIDTH_DEF = 32;
    localparam int GD_WIDTH_DEF = 32;
    // Widest comparison the range helper supports; callers sign-extend into it.
    localparam int CMP_MAX      = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Exclusive bound: below lim for a rising loop, above lim for a falling one.
    function automatic logic in_range(input logic signed [CMP_MAX-1:0] value,
                                      input logic signed [CMP_MAX-1:0] lim,
                                      input logic                      gd_neg);
        return gd_neg ? (value > lim) : (value < lim);
    endfunction

endpackage

// File: rtl/gc_prefix_count.sv
// Exclusive prefix popcount: k[i] = number of set bits below i, plus the total.
module gc_prefix_count
    import gc_pkg::*;
#(
    parameter int N  = N_CORE_DEF,
    parameter int KW = $clog2(N + 1)
) (
    input  logic [N-1:0]         vec,
    output logic [N-1:0][KW-1:0] k,
    output logic [KW-1:0]        total
);

    logic [KW-1:0] acc;

    always_comb begin
        acc = '0;
        k   = '0;
        for (int i = 0; i < N; i++) begin
            k[i] = acc;
            acc  = acc + KW'(vec[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/gc_dispatch.sv
// Hands out loop iterations gc, gc+gd, ... to requesting cores in index order.
module gc_dispatch
    import gc_pkg::*;
#(
    parameter int N_CORE   = N_CORE_DEF,
    parameter int GC_WIDTH = GC_WIDTH_DEF,
    parameter int GD_WIDTH = GD_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             fork_valid,
    output logic                             fork_ready,
    input  logic [GC_WIDTH-1:0]              fork_gc,
    input  logic [GD_WIDTH-1:0]              fork_gd,
    input  logic [GC_WIDTH-1:0]              fork_limit,
    input  logic [N_CORE-1:0]                req_valid,
    output logic [N_CORE-1:0]                req_ready,
    output logic [N_CORE-1:0][GC_WIDTH-1:0]  grant_gc,
    input  logic [N_CORE-1:0]                core_done,
    output logic                             busy,
    output logic                             all_done
);

    localparam int KW = $clog2(N_CORE + 1);
    // Wide enough that gc + N_CORE*gd can never wrap back into range.
    localparam int CW = GC_WIDTH + KW + 1;

    state_t                      state;
    logic signed [GC_WIDTH-1:0]  gc, gd, lim;

    logic [N_CORE-1:0][KW-1:0]   k;
    logic [KW-1:0]               total;
    logic [KW-1:0]               g_cnt;
    logic signed [CW-1:0]        gc_x, gd_x, lim_x, next_gc;
    logic signed [CW-1:0]        cand [N_CORE];
    logic                        run, next_ok, refused, fork_drain;

    gc_prefix_count #(.N(N_CORE), .KW(KW)) u_prefix (
        .vec   (req_valid),
        .k     (k),
        .total (total)
    );

    always_comb begin
        run     = rst_n && (state == RUN);
        gc_x    = CW'(gc);
        gd_x    = CW'(gd);
        lim_x   = CW'(lim);
        g_cnt   = '0;
        req_ready = '0;
        grant_gc  = '0;
        for (int i = 0; i < N_CORE; i++) begin
            cand[i] = gc_x + CW'($signed({1'b0, k[i]})) * gd_x;
            req_ready[i] = run && req_valid[i] &&
                           in_range(CMP_MAX'(cand[i]), CMP_MAX'(lim_x), gd[GC_WIDTH-1]);
            grant_gc[i]  = req_ready[i] ? cand[i][GC_WIDTH-1:0] : '0;
            g_cnt        = g_cnt + KW'(req_ready[i]);
        end
        next_gc = gc_x + CW'($signed({1'b0, g_cnt})) * gd_x;
        next_ok = in_range(CMP_MAX'(next_gc), CMP_MAX'(lim_x), gd[GC_WIDTH-1]);
        refused = (g_cnt != total);
        fork_drain = (fork_gd == '0) ||
                     !in_range(CMP_MAX'($signed(fork_gc)), CMP_MAX'($signed(fork_limit)),
                               fork_gd[GD_WIDTH-1]);
    end

    assign fork_ready = (state == IDLE);
    assign busy       = rst_n && (state != IDLE);
    assign all_done   = rst_n && (state == DRAIN) && (&core_done);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            gc    <= '0;
            gd    <= '0;
            lim   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fork_valid) begin
                        gc    <= fork_gc;
                        gd    <= GC_WIDTH'($signed(fork_gd));
                        lim   <= fork_limit;
                        state <= fork_drain ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (!next_ok || refused) state <= DRAIN;
                    else                     gc    <= next_gc[GC_WIDTH-1:0];
                end
                DRAIN: begin
                    if (&core_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gc_dispatch.md
GC_DISPATCH -- requirements
Module: gc_dispatch

Interface
REQ-001 SHALL have parameter N_CORE, default 4, meaning number of requesting cores (1..16).
REQ-002 SHALL have parameter GC_WIDTH, default 32, meaning iteration-counter width.
REQ-003 SHALL have parameter GD_WIDTH, default 32, meaning signed stride width (GD_WIDTH <= GC_WIDTH).
REQ-004 SHALL have port clk  in  1  meaning the single clock.
REQ-005 SHALL have port rst_n  in  1  meaning reset, synchronous and active-low.
REQ-006 SHALL have port fork_valid  in  1  meaning a loop-start request.
REQ-007 SHALL have port fork_ready  out  1  meaning a fork is accepted this cycle.
REQ-008 SHALL have port fork_gc  in  GC_WIDTH  meaning the signed start value.
REQ-009 SHALL have port fork_gd  in  GD_WIDTH  meaning the signed stride.
REQ-010 SHALL have port fork_limit  in  GC_WIDTH  meaning the signed exclusive bound.
REQ-011 SHALL have port req_valid  in  N_CORE  meaning per-core iteration request.
REQ-012 SHALL have port req_ready  out  N_CORE  meaning per-core grant.
REQ-013 SHALL have port grant_gc  out  N_CORE x GC_WIDTH  meaning the iteration value for each core, valid when its req_ready is 1.
REQ-014 SHALL have port core_done  in  N_CORE  meaning the core has finished (level).
REQ-015 SHALL have port busy  out  1  meaning the state is not IDLE.
REQ-016 SHALL have port all_done  out  1  meaning a one-cycle loop-complete pulse.

Function
REQ-017 SHALL implement states IDLE, RUN and DRAIN.
REQ-018 In IDLE, SHALL drive fork_ready=1; when fork_valid=1, SHALL load gc<=fork_gc, gd<=sign-extended fork_gd and lim<=fork_limit.
REQ-019 On a fork, SHALL go to RUN, or to DRAIN if fork_gd==0 or fork_gc is out of range.
REQ-020 In RUN, SHALL give core i the offset k_i, the count of set req_valid[j] for j<i (index-order priority).
REQ-021 SHALL set grant_gc[i] = gc + k_i*gd.
REQ-022 SHALL define in range as value<lim when gd>0 and value>lim when gd<0.
REQ-023 SHALL make comparisons signed at GC_WIDTH+$clog2(N_CORE+1)+1 bits, so that candidate overflow never wraps into range.
REQ-024 SHALL drive req_ready[i]=1 only when in RUN, req_valid[i]=1 and grant_gc[i] is in range; req_ready is combinational from req_valid with zero latency.
REQ-025 SHALL, per cycle, advance gc by G*gd, where G is the number of grants; the truncation to GC_WIDTH is not used when the result is out of range.
REQ-026 SHALL go from RUN to DRAIN in the cycle after the updated gc becomes out of range, or immediately if any valid request was refused for range.
REQ-027 In DRAIN, SHALL drive req_ready=0; when &core_done==1, SHALL pulse all_done=1 for one cycle and return to IDLE.
REQ-028 SHALL ignore fork_valid outside IDLE, with fork_ready=0.
REQ-029 SHALL drive grant_gc[i]=0 when req_ready[i]=0.

Reset
REQ-030 When rst_n=0 at a clk edge, SHALL enter IDLE with gc=0, gd=0 and lim=0.
REQ-031 SHALL drive outputs during reset as req_ready=0, grant_gc=0, all_done=0, busy=0 and fork_ready=1 from the cycle after reset.
REQ-032 A reset in the middle of RUN or DRAIN SHALL abandon the loop with no all_done pulse.

Structure
REQ-033 SHALL place the state enum, the N_CORE/GC_WIDTH/GD_WIDTH defaults and the in-range helper function in the shared package gc_pkg.
REQ-034 SHALL contain one sub-module, gc_prefix_count, which returns the exclusive prefix popcount of req_valid (k_i) and the total.
REQ-035 SHALL register only state, gc, gd and lim; the grant path is combinational.

Verification
REQ-036 SHALL cover: fork 0/1/10 with req_valid=4'hF every cycle -> grants 0-3, then 4-7, then 8,9 to cores 0 and 1 with req_ready[3:2]=0, then DRAIN.
REQ-037 SHALL cover: gc=50, gd=5, req_valid=4'b1010 -> core1 gets 50, core3 gets 55, next gc=60.
REQ-038 SHALL cover: fork 20/-3/10 -> grants 20, 17, 14, 11 across cores 0-3, then DRAIN; core_done=4'hF -> all_done for 1 cycle, then IDLE.
REQ-039 SHALL cover: fork_gd=0 -> DRAIN directly, no req_ready ever, busy=1 until &core_done.
REQ-040 SHALL cover: GC_WIDTH=8, fork 100/100/127 with all valid -> only core0 granted 100; 200 is not wrapped to -56.
REQ-041 SHALL cover: fork_valid in RUN is ignored (gc unchanged); rst_n=0 in RUN -> next cycle IDLE, req_ready=0, fork_ready=1, no all_done.
